// File: rtl/index_table_sequencer.sv
// rtl/index_table_sequencer.sv - streams layer mask words through index_table_logic into the index table
module index_table_sequencer #(
  parameter int MEM_BW           = 128,
  parameter int ADDR_WIDTH_MASKS = 11,
  parameter int ADDR_WIDTH_INDEX = 10
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        start,
  input  logic [ADDR_WIDTH_MASKS-1:0] mask_base,
  input  logic [ADDR_WIDTH_MASKS:0]   num_masks,
  input  logic                        hold,
  output logic                        masks_re,
  output logic [ADDR_WIDTH_MASKS-1:0] masks_addr,
  output logic                        CE_signal,
  output logic [31:0]                 masks_transferred,
  input  logic                        delayed_CE,
  input  logic [ADDR_WIDTH_MASKS-1:0] delayed_masks_transferred,
  input  logic [31:0]                 activation_rows_total,
  output logic                        index_we,
  output logic [ADDR_WIDTH_INDEX-1:0] index_addr,
  output logic [31:0]                 index_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [31:0]                 layer_rows
);

  localparam int CW = ADDR_WIDTH_MASKS + 1;

  // Mask words pass straight from the SRAM into index_table_logic, so the
  // word width only has to agree between those two blocks.
  if (MEM_BW < 16) begin : g_mem_bw_narrow
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t                      state;
  state_t                      state_nxt;

  logic [ADDR_WIDTH_MASKS-1:0] base_q;
  logic [CW-1:0]               num_q;
  logic [CW-1:0]               half_num;
  logic [CW-1:0]               rd_cnt;
  logic [CW-1:0]               wr_cnt;
  logic                        err_q;
  logic [31:0]                 base_total;
  logic [31:0]                 last_wdata;
  logic [31:0]                 last_total;

  logic                        start_ok;
  logic                        start_bad;
  logic                        wr_hit;
  logic                        wr_done;
  logic [ADDR_WIDTH_MASKS-1:0] pair_idx;
  logic [31:0]                 rebased;

  assign half_num = num_q >> 1;

  // State register
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, read issue and the combinational index-table write path
  always_comb begin
    state_nxt   = state;
    masks_re    = 1'b0;
    masks_addr  = '0;
    index_we    = 1'b0;
    index_addr  = '0;
    index_wdata = '0;
    start_ok    = 1'b0;
    start_bad   = 1'b0;
    busy        = (state == S_ISSUE) || (state == S_DRAIN);
    done        = (state == S_FIN);
    err         = (state == S_FIN) && err_q;

    // Only the odd word of a pair closes it, so only odd words write.
    pair_idx = delayed_masks_transferred >> 1;
    rebased  = activation_rows_total - base_total;
    wr_hit   = delayed_CE && delayed_masks_transferred[0] &&
               ((state == S_ISSUE) || (state == S_DRAIN));
    if (wr_hit) begin
      index_we    = 1'b1;
      index_addr  = ADDR_WIDTH_INDEX'(pair_idx);
      index_wdata = rebased;
    end

    // A write landing this cycle counts toward completion immediately.
    if (wr_hit) begin
      wr_done = ((wr_cnt + CW'(1)) == half_num);
    end else begin
      wr_done = (wr_cnt == half_num);
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          if ((num_masks == '0) || num_masks[0]) begin
            start_bad = 1'b1;
            state_nxt = S_FIN;
          end else begin
            start_ok  = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          masks_re   = 1'b1;
          masks_addr = base_q + rd_cnt[ADDR_WIDTH_MASKS-1:0];
          if (rd_cnt == (num_q - CW'(1))) begin
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (wr_done) begin
          state_nxt = S_FIN;
        end
      end
      S_FIN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Run configuration, read/write counters and the reject flag
  always_ff @(posedge clk) begin
    if (rst_in) begin
      base_q <= '0;
      num_q  <= '0;
      rd_cnt <= '0;
      wr_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (start_bad) begin
        err_q <= 1'b1;
      end
      if (start_ok) begin
        base_q <= mask_base;
        num_q  <= num_masks;
        rd_cnt <= '0;
        wr_cnt <= '0;
        err_q  <= 1'b0;
      end else begin
        if (masks_re) begin
          rd_cnt <= rd_cnt + CW'(1);
        end
        if (index_we) begin
          wr_cnt <= wr_cnt + CW'(1);
        end
      end
    end
  end

  // Read-return stage: SRAM data is valid one cycle after masks_re
  always_ff @(posedge clk) begin
    if (rst_in) begin
      CE_signal         <= 1'b0;
      masks_transferred <= '0;
    end else begin
      CE_signal <= masks_re;
      if (masks_re) begin
        masks_transferred <= 32'(rd_cnt);
      end
    end
  end

  // Track the last write and rebase the running total at the end of a good layer
  always_ff @(posedge clk) begin
    if (rst_in) begin
      last_wdata <= '0;
      last_total <= '0;
      layer_rows <= '0;
      base_total <= '0;
    end else begin
      if (index_we) begin
        last_wdata <= index_wdata;
        last_total <= activation_rows_total;
      end
      if ((state == S_FIN) && !err_q) begin
        layer_rows <= last_wdata;
        base_total <= last_total;
      end
    end
  end

endmodule

// File: doc/index_table_sequencer.md
# index_table_sequencer

Controller that streams one layer's sparsity-mask words from the mask SRAM through `index_table_logic` and writes the resulting per-pair cumulative activation-row counts into the index table SRAM. It generates `CE_signal`/`masks_transferred` for `index_table_logic`, consumes its delayed outputs, and rebases the running total so each layer's index table starts from zero. It sits between the layer controller (start/done) and the mask/index memories.

## Interface

- `MEM_BW`, 128: mask word width; must match `index_table_logic`.
- `ADDR_WIDTH_MASKS`, 11: mask SRAM address width.
- `ADDR_WIDTH_INDEX`, 10: index table address width.
- `clk`  in  1  clock; all logic on rising edge.
- `rst_in`  in  1  reset: synchronous, active-high.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `mask_base`  in  ADDR_WIDTH_MASKS  first mask address; sampled with `start`.
- `num_masks`  in  ADDR_WIDTH_MASKS+1  mask words in the layer; sampled with `start`.
- `hold`  in  1  while high, no new mask read is issued; in-flight words complete.
- `masks_re`  out  1  mask SRAM read enable; data returns 1 cycle later.
- `masks_addr`  out  ADDR_WIDTH_MASKS  mask SRAM address.
- `CE_signal`  out  1  to `index_table_logic`: mask word valid this cycle.
- `masks_transferred`  out  32  to `index_table_logic`: word index within the layer (0-based).
- `delayed_CE`  in  1  from `index_table_logic`.
- `delayed_masks_transferred`  in  ADDR_WIDTH_MASKS  from `index_table_logic`.
- `activation_rows_total`  in  32  from `index_table_logic`: running row total, never cleared by that block.
- `index_we`  out  1  index SRAM write enable; always accepted.
- `index_addr`  out  ADDR_WIDTH_INDEX  pair index = `delayed_masks_transferred >> 1`.
- `index_wdata`  out  32  `activation_rows_total - base_total`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`: the run was rejected.
- `layer_rows`  out  32  rows used by the last completed layer; held until the next `done`.

## Operation

- States: IDLE, ISSUE, DRAIN, FIN.
- **IDLE.** On `start`:
  - If `num_masks` is 0 or odd, go to FIN with `err`=1. No reads are issued and no internal state other than `err` changes.
  - Otherwise latch `mask_base` and `num_masks`, clear the read counter `rd_cnt` and the write counter `wr_cnt`, and go to ISSUE.
- **ISSUE.** Each cycle with `hold`=0:
  - `masks_re`=1 and `masks_addr` = `mask_base + rd_cnt`, wrapping modulo 2^ADDR_WIDTH_MASKS.
  - `rd_cnt` increments.
  - After the read with `rd_cnt` = `num_masks-1`, go to DRAIN.
  - With `hold`=1: `masks_re`=0 and the counters are frozen.
- **Read-return stage.** This is a single register stage, not gated by `hold`:
  - `CE_signal` = `masks_re` from the previous cycle.
  - `masks_transferred` = `rd_cnt` value of that read, zero-extended.
- **Index writes.** On any cycle with `delayed_CE`=1 and `delayed_masks_transferred[0]`=1:
  - `index_we`=1, `index_addr` = `delayed_masks_transferred >> 1`, `index_wdata` = `activation_rows_total - base_total`, mod 2^32.
  - `wr_cnt` increments.
  - This is active in ISSUE and DRAIN. Even-index words produce no write.
- **DRAIN.** Stay until `wr_cnt` = `num_masks/2` is reached, including a write occurring in the same cycle. Then go to FIN.
- **FIN.** One cycle: `done`=1.
  - If `err`=0: `layer_rows` gets the last `index_wdata` written, and `base_total` gets the last `activation_rows_total` written.
  - Then return to IDLE.
- `start` outside IDLE is ignored.
- **Reset** (`rst_in`=1 at an edge), also valid mid-run: state goes to IDLE. All outputs become 0 next cycle: `masks_re`, `masks_addr`, `CE_signal`, `masks_transferred`, `index_we`, `index_addr`, `index_wdata`, `busy`, `done`, `err`, `layer_rows`. `base_total`, `rd_cnt` and `wr_cnt` also clear. `index_table_logic` runs on its own reset; system reset asserts both together.

## Timing

- `start` at cycle T with N valid. With no `hold`:
  - reads at T+1..T+N;
  - `CE_signal` at T+2..T+N+1;
  - writes at T+5, T+7, …, T+N+3;
  - `done` at T+N+4.
- `busy` covers T+1..T+N+3.
- Write latency: `CE_signal` for the odd word k, to `index_we` for pair k>>1, is exactly 2 cycles (the `index_table_logic` pipeline). The sequencer adds no stage on the write path; `index_*` outputs are combinational from the delayed inputs and `base_total`.
- `hold` for H cycles during ISSUE delays `done` by exactly H. `hold` in DRAIN/FIN/IDLE has no effect.
- Rejected start at T: `done`=`err`=1 at T+1, `busy` stays 0.
- Back-to-back: a new `start` is accepted in the cycle after `done` at the earliest.

## Test plan

- **N=4, all mask bits 1, base 0.** Reads at addresses 0..3. Index writes {addr0: 16, addr1: 32} at T+5 and T+7. `done` at T+8, `layer_rows`=32.
- **Second layer after the first, N=2, masks 0x…01 / 0x0.** With the counters persisting in `index_table_logic`: index write addr0 = 1, not 33. `layer_rows`=1.
- **N=6 with `hold` high for 3 cycles after the second read.** No `masks_re` during `hold`. `done` at T+13 and the write contents are unchanged versus no-hold.
- **`num_masks`=3, then `num_masks`=0.** Each gives `done`&`err` at T+1, no `masks_re`, no `index_we`, and `layer_rows` unchanged.
- **`mask_base`=2^11−2, N=4.** `masks_addr` sequence is 2046, 2047, 0, 1.
- **Reset asserted at T+4 of an N=8 run.** All outputs are 0 from the next cycle. A fresh `start` then completes normally with `base_total`=0.
